// File: rtl/mmu_pkg.sv
// Shared constants for the banked MMU: register offsets, CR/MCR/RCR field
// positions, the common-region size table and reset values.
package mmu_pkg;

  localparam int unsigned CR_IO_BIT     = 0;
  localparam int unsigned MCR_OS_BIT    = 6;
  localparam int unsigned RCR_LO_EN_BIT = 2;
  localparam int unsigned RCR_HI_EN_BIT = 3;

  // Only these MCR bits are writable; the rest keep their reset value.
  localparam logic [7:0] MCR_WR_MASK = 8'b0111_1001;

  localparam logic [7:0] CR_RST   = 8'h00;
  localparam logic [7:0] PCR_RST  = 8'h00;
  localparam logic [7:0] MCR_RST  = 8'hB0;
  localparam logic [7:0] RCR_RST  = 8'h00;
  localparam logic [7:0] P0_RST   = 8'h00;
  localparam logic [7:0] P1_RST   = 8'h01;
  localparam logic [7:0] VER_RST  = 8'h00;

  typedef enum logic [1:0] {
    CSZ_1K  = 2'd0,
    CSZ_4K  = 2'd1,
    CSZ_8K  = 2'd2,
    CSZ_16K = 2'd3
  } csize_e;

  // Region size minus one: low region is addr & ~mask == 0, high is addr | mask == FFFF.
  function automatic logic [15:0] common_mask(input csize_e sz);
    case (sz)
      CSZ_1K:  return 16'h03FF;
      CSZ_4K:  return 16'h0FFF;
      CSZ_8K:  return 16'h1FFF;
      default: return 16'h3FFF;
    endcase
  endfunction

  localparam int unsigned OFF_CR = 0;

  function automatic int unsigned off_pcr(input int unsigned i);
    return 1 + i;
  endfunction
  function automatic int unsigned off_mcr(input int unsigned p);
    return p + 1;
  endfunction
  function automatic int unsigned off_rcr(input int unsigned p);
    return p + 2;
  endfunction
  function automatic int unsigned off_p0l(input int unsigned p);
    return p + 3;
  endfunction
  function automatic int unsigned off_p0h(input int unsigned p);
    return p + 4;
  endfunction
  function automatic int unsigned off_p1l(input int unsigned p);
    return p + 5;
  endfunction
  function automatic int unsigned off_p1h(input int unsigned p);
    return p + 6;
  endfunction
  function automatic int unsigned off_vr(input int unsigned p);
    return p + 7;
  endfunction

endpackage

// File: rtl/mmu_xlate.sv
// Address translation stage: page relocation, common regions, CR bank select,
// registered pa/valid/io_sel. Page relocation compiled in with MMU_RELOC_EN.
module mmu_xlate
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_W = 16,
  parameter int unsigned BANK_W = 2
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     en_i,
  input  logic [ADDR_W-1:0]        addr_i,
  input  logic [BANK_W-1:0]        cr_bank_i,
  input  logic                     cr_io_i,
  input  logic [1:0]               rcr_size_i,
  input  logic                     rcr_lo_en_i,
  input  logic                     rcr_hi_en_i,
`ifdef MMU_RELOC_EN
  input  logic [BANK_W+7:0]        p0_i,
  input  logic [BANK_W+7:0]        p1_i,
`endif
  output logic [BANK_W+ADDR_W-1:0] pa_o,
  output logic                     valid_o,
  output logic                     io_sel_o
);

  logic [BANK_W+ADDR_W-1:0] pa_q, pa_d;
  logic                     valid_q;
  logic                     io_q, io_d;
  logic [BANK_W-1:0]        bank_d;
  logic [7:0]               page, page_d;
  logic [15:0]              mask;
  logic                     common_hit;
  logic                     reloc_hit;
  logic [ADDR_W-1:0]        addr_x;

  assign page = addr_i[15:8];
  assign mask = common_mask(csize_e'(rcr_size_i));
  assign common_hit = (rcr_lo_en_i && ((addr_i[15:0] & ~mask) == '0)) ||
                      (rcr_hi_en_i && ((addr_i[15:0] |  mask) == '1));

  always_comb begin
    bank_d    = cr_bank_i;
    page_d    = page;
    reloc_hit = 1'b0;
`ifdef MMU_RELOC_EN
    reloc_hit = 1'b1;
    if (page == 8'h00) begin
      {bank_d, page_d} = p0_i;
    end else if (page == p0_i[7:0] && cr_bank_i == p0_i[BANK_W+7:8]) begin
      bank_d = '0;
      page_d = 8'h00;
    end else if (page == 8'h01) begin
      {bank_d, page_d} = p1_i;
    end else if (page == p1_i[7:0] && cr_bank_i == p1_i[BANK_W+7:8]) begin
      bank_d = '0;
      page_d = 8'h01;
    end else begin
      reloc_hit = 1'b0;
    end
`endif
    if (!reloc_hit && common_hit) bank_d = '0;
    addr_x       = addr_i;
    addr_x[15:8] = page_d;
    pa_d         = {bank_d, addr_x};
    io_d         = !cr_io_i && (addr_i[15:12] == 4'hD);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pa_q    <= '0;
      valid_q <= 1'b0;
      io_q    <= 1'b0;
    end else begin
      valid_q <= en_i;
      if (en_i) begin
        pa_q <= pa_d;
        io_q <= io_d;
      end
    end
  end

  assign pa_o     = pa_q;
  assign valid_o  = valid_q;
  assign io_sel_o = io_q;

endmodule

// File: rtl/mmu_banked.sv
// Banked MMU top: CR/PCR/MCR/RCR register file with LCR window, optional
// P0/P1 page relocation (MMU_RELOC_EN), and the mmu_xlate translation stage.
module mmu_banked
  import mmu_pkg::*;
#(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned BANK_W   = 2,
  parameter int unsigned NUM_PCR  = 4,
  parameter logic [15:0] IO_BASE  = 16'hD500,
  parameter logic [15:0] LCR_BASE = 16'hFF00,
  parameter logic [7:0]  VERSION  = 8'h20
) (
  input  logic                     clk,
  input  logic                     reset_in,
  input  logic                     bus_en_in,
  input  logic                     rw_in,
  input  logic [ADDR_W-1:0]        addr_in,
  input  logic [7:0]               d_in,
  output logic [7:0]               d_out,
  output logic                     d_oe,
  output logic [BANK_W+ADDR_W-1:0] pa_out,
  output logic                     pa_valid,
  output logic                     io_sel_out,
  output logic                     ms3_out
);

  localparam logic [15:0] K_CR  = 16'(OFF_CR);
  localparam logic [15:0] K_MCR = 16'(off_mcr(NUM_PCR));
  localparam logic [15:0] K_RCR = 16'(off_rcr(NUM_PCR));
  localparam logic [15:0] K_P0L = 16'(off_p0l(NUM_PCR));
  localparam logic [15:0] K_P0H = 16'(off_p0h(NUM_PCR));
  localparam logic [15:0] K_P1L = 16'(off_p1l(NUM_PCR));
  localparam logic [15:0] K_P1H = 16'(off_p1h(NUM_PCR));
  localparam logic [15:0] K_VR  = 16'(off_vr(NUM_PCR));
  localparam logic [15:0] K_LCR = 16'(NUM_PCR);
  localparam logic [7:0]  HI_FILL = {{(8-BANK_W){1'b1}}, {BANK_W{1'b0}}};

  logic [7:0] cr_q, cr_d, mcr_q, mcr_d, rcr_q, rcr_d;
  logic [7:0] pcr_q [NUM_PCR];
  logic [7:0] pcr_d [NUM_PCR];
  logic [7:0] d_out_q, rd_data;
  logic       d_oe_q, rd_hit;
  logic [15:0] a16, io_off, lcr_off;
  logic        io_hit, lcr_hit, wr;

`ifdef MMU_RELOC_EN
  logic [BANK_W+7:0] p0_q, p0_d, p1_q, p1_d;
  logic [BANK_W-1:0] p0h_q, p0h_d, p1h_q, p1h_d;
`endif

  assign a16     = addr_in[15:0];
  assign io_off  = a16 - IO_BASE;
  assign lcr_off = a16 - LCR_BASE;
  assign io_hit  = (a16 >= IO_BASE) && (io_off <= K_VR);
  assign lcr_hit = (a16 >= LCR_BASE) && (lcr_off <= K_LCR);
  assign wr      = bus_en_in && !rw_in;

  always_comb begin
    rd_hit  = 1'b0;
    rd_data = '0;
    if (io_hit) begin
      rd_hit = 1'b1;
      if (io_off == K_CR)  rd_data = cr_q;
      for (int unsigned i = 0; i < NUM_PCR; i++)
        if (io_off == 16'(off_pcr(i))) rd_data = pcr_q[i];
      if (io_off == K_MCR) rd_data = mcr_q;
      if (io_off == K_RCR) rd_data = rcr_q;
`ifdef MMU_RELOC_EN
      if (io_off == K_P0L) rd_data = p0_q[7:0];
      if (io_off == K_P0H) rd_data = HI_FILL | 8'(p0h_q);
      if (io_off == K_P1L) rd_data = p1_q[7:0];
      if (io_off == K_P1H) rd_data = HI_FILL | 8'(p1h_q);
`else
      if (io_off == K_P0L) rd_data = P0_RST;
      if (io_off == K_P0H) rd_data = HI_FILL;
      if (io_off == K_P1L) rd_data = P1_RST;
      if (io_off == K_P1H) rd_data = HI_FILL;
`endif
      if (io_off == K_VR)  rd_data = VERSION;
    end else if (lcr_hit) begin
      rd_hit = 1'b1;
      if (lcr_off == '0) rd_data = cr_q;
      for (int unsigned i = 0; i < NUM_PCR; i++)
        if (lcr_off == 16'(i + 1)) rd_data = pcr_q[i];
    end
  end

  always_comb begin
    cr_d  = cr_q;
    pcr_d = pcr_q;
    mcr_d = mcr_q;
    rcr_d = rcr_q;
`ifdef MMU_RELOC_EN
    p0_d  = p0_q;
    p1_d  = p1_q;
    p0h_d = p0h_q;
    p1h_d = p1h_q;
`endif
    if (wr && io_hit) begin
      if (io_off == K_CR)  cr_d = d_in;
      for (int unsigned i = 0; i < NUM_PCR; i++)
        if (io_off == 16'(off_pcr(i))) pcr_d[i] = d_in;
      if (io_off == K_MCR) mcr_d = (mcr_q & ~MCR_WR_MASK) | (d_in & MCR_WR_MASK);
      if (io_off == K_RCR) rcr_d = d_in;
`ifdef MMU_RELOC_EN
      // High bytes only stage; the low-byte write commits the full page pointer.
      if (io_off == K_P0H) p0h_d = d_in[BANK_W-1:0];
      if (io_off == K_P0L) p0_d  = {p0h_q, d_in};
      if (io_off == K_P1H) p1h_d = d_in[BANK_W-1:0];
      if (io_off == K_P1L) p1_d  = {p1h_q, d_in};
`endif
    end else if (wr && lcr_hit) begin
      if (lcr_off == '0) cr_d = d_in;
      for (int unsigned i = 0; i < NUM_PCR; i++)
        if (lcr_off == 16'(i + 1)) cr_d = pcr_q[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset_in) begin
      cr_q    <= CR_RST;
      pcr_q   <= '{default: PCR_RST};
      mcr_q   <= MCR_RST;
      rcr_q   <= RCR_RST;
      d_out_q <= '0;
      d_oe_q  <= 1'b0;
`ifdef MMU_RELOC_EN
      p0_q    <= {{BANK_W{1'b0}}, P0_RST};
      p1_q    <= {{BANK_W{1'b0}}, P1_RST};
      p0h_q   <= '0;
      p1h_q   <= '0;
`endif
    end else begin
      cr_q   <= cr_d;
      pcr_q  <= pcr_d;
      mcr_q  <= mcr_d;
      rcr_q  <= rcr_d;
      d_oe_q <= bus_en_in && rw_in && rd_hit;
      if (bus_en_in && rw_in && rd_hit) d_out_q <= rd_data;
`ifdef MMU_RELOC_EN
      p0_q   <= p0_d;
      p1_q   <= p1_d;
      p0h_q  <= p0h_d;
      p1h_q  <= p1h_d;
`endif
    end
  end

  mmu_xlate #(
    .ADDR_W (ADDR_W),
    .BANK_W (BANK_W)
  ) u_xlate (
    .clk_i       (clk),
    .rst_i       (reset_in),
    .en_i        (bus_en_in),
    .addr_i      (addr_in),
    .cr_bank_i   (cr_q[7 -: BANK_W]),
    .cr_io_i     (cr_q[CR_IO_BIT]),
    .rcr_size_i  (rcr_q[1:0]),
    .rcr_lo_en_i (rcr_q[RCR_LO_EN_BIT]),
    .rcr_hi_en_i (rcr_q[RCR_HI_EN_BIT]),
`ifdef MMU_RELOC_EN
    .p0_i        (p0_q),
    .p1_i        (p1_q),
`endif
    .pa_o        (pa_out),
    .valid_o     (pa_valid),
    .io_sel_o    (io_sel_out)
  );

  assign d_out   = d_out_q;
  assign d_oe    = d_oe_q;
  assign ms3_out = mcr_q[MCR_OS_BIT];

endmodule
